// File: rtl/mips_control_fsm_if.sv
// ----------------------------------------------------------------------------
// mips_control_fsm_if
// Purpose : bundles the datapath-facing signals of the multi-cycle MIPS
//           control unit so the controller and its environment share one
//           connection.
// Signals :
//   opcode[5:0]   instruction bits [31:26] from the instruction register
//   zero          ALU zero flag
//   mem_ready     memory completion strobe
//   mem_req       memory access request
//   mem_write     1 = write, 0 = read (qualifies mem_req)
//   ir_write      load instruction register
//   pc_write      update PC
//   reg_dst       write-register select (0 = rt, 1 = rd)
//   alu_src       ALU B select (0 = register, 1 = sign-extended immediate)
//   mem_to_reg    write-data select (0 = ALU result, 1 = memory data)
//   pc_src        PC select (0 = PC+4, 1 = branch target)
//   jump          PC select override to jump target
//   reg_write     register file write enable
//   alu_op[1:0]   00 add, 01 sub, 10 decode funct
//   illegal       one-cycle pulse on unsupported opcode
//   state[3:0]    current state encoding (debug)
//   retired[15:0] count of completed instructions
// Modports: master = datapath/environment side, slave = controller side.
// ----------------------------------------------------------------------------
interface mips_control_fsm_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        pc_src;
    logic        jump;
    logic        reg_write;
    logic [1:0]  alu_op;
    logic        illegal;
    logic [3:0]  state;
    logic [15:0] retired;

    modport master (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, ir_write, pc_write, reg_dst, alu_src,
               mem_to_reg, pc_src, jump, reg_write, alu_op, illegal,
               state, retired
    );

    modport slave (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, ir_write, pc_write, reg_dst, alu_src,
               mem_to_reg, pc_src, jump, reg_write, alu_op, illegal,
               state, retired
    );
endinterface

// File: rtl/mips_control_fsm.sv
// ----------------------------------------------------------------------------
// mips_control_fsm
// Purpose : multi-cycle MIPS control unit (R-type, lw, sw, beq, j, addi).
//           Sequences fetch/decode/execute/memory/writeback states, drives
//           the datapath selects and strobes, flags unsupported opcodes and
//           counts retired instructions.
// Ports   :
//   clock  in   sole clock, rising edge
//   reset  in   synchronous, active-low
//   bus    slave modport of mips_control_fsm_if (see that file for signals)
// ----------------------------------------------------------------------------
module mips_control_fsm (
    input  logic              clock,
    input  logic              reset,
    mips_control_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_opcode;
    logic [5:0]  w_opcode_next;
    logic [15:0] r_retired;
    logic [15:0] w_retired_next;
    logic        w_retire;

    logic        w_mem_req;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_reg_dst;
    logic        w_alu_src;
    logic        w_mem_to_reg;
    logic        w_pc_src;
    logic        w_jump;
    logic        w_reg_write;
    logic [1:0]  w_alu_op;
    logic        w_illegal;

    // State register, latched opcode and retire counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_opcode  <= 6'b000000;
            r_retired <= 16'd0;
        end else begin
            r_state   <= w_state_next;
            r_opcode  <= w_opcode_next;
            r_retired <= w_retired_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next  = S_FETCH;
        w_opcode_next = r_opcode;
        w_retire      = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_dst     = 1'b0;
        w_alu_src     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_pc_src      = 1'b0;
        w_jump        = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_op      = 2'b00;
        w_illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // Later states work from this copy so a changing
                // instruction register cannot redirect them.
                w_opcode_next = bus.opcode;
                case (bus.opcode)
                    OP_RTYPE:     w_state_next = S_R_EXEC;
                    OP_LW, OP_SW: w_state_next = S_MEM_ADDR;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_J:         w_state_next = S_JUMP;
                    OP_ADDI:      w_state_next = S_ADDI_EXEC;
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src    = 1'b1;
                w_state_next = (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                w_mem_req    = 1'b1;
                w_state_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                if (bus.mem_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_MEM_WRITE;
                end
            end
            S_R_EXEC: begin
                w_alu_op     = 2'b10;
                w_state_next = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_op     = 2'b01;
                w_pc_src     = 1'b1;
                w_pc_write   = bus.zero;   // taken only when operands match
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                w_jump       = 1'b1;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                w_alu_src    = 1'b1;
                w_state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            default: begin
                // Unused encodings: all strobes stay low, recover to fetch.
                w_state_next = S_FETCH;
            end
        endcase

        // While reset is held the unit presents a quiet fetch request,
        // whatever state it is leaving, so no stray strobe reaches the
        // datapath before the reset edge lands.
        if (!reset) begin
            w_mem_req    = 1'b1;
            w_mem_write  = 1'b0;
            w_ir_write   = 1'b0;
            w_pc_write   = 1'b0;
            w_reg_dst    = 1'b0;
            w_alu_src    = 1'b0;
            w_mem_to_reg = 1'b0;
            w_pc_src     = 1'b0;
            w_jump       = 1'b0;
            w_reg_write  = 1'b0;
            w_alu_op     = 2'b00;
            w_illegal    = 1'b0;
        end

        w_retired_next = w_retire ? (r_retired + 16'd1) : r_retired;
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_write  = w_mem_write;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.alu_src    = w_alu_src;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.pc_src     = w_pc_src;
    assign bus.jump       = w_jump;
    assign bus.reg_write  = w_reg_write;
    assign bus.alu_op     = w_alu_op;
    assign bus.illegal    = w_illegal;
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- opcode  in  6  instruction bits [31:26], taken from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion strobe.
- mem_req  out  1  memory access request.
- mem_write  out  1  1 = write, 0 = read; qualifies mem_req.
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- alu_src  out  1  ALU B select: 0 = register, 1 = sign-extended immediate.
- mem_to_reg  out  1  write-data select: 0 = ALU result, 1 = memory data.
- pc_src  out  1  PC select: 0 = PC+4, 1 = branch target.
- jump  out  1  PC select override: jump target.
- reg_write  out  1  register file write enable.
- alu_op  out  2  00 add, 01 sub, 10 decode funct.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- state  out  4  current state encoding, for debug.
- retired  out  16  count of completed instructions.

Function
REQ-002 States and encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
REQ-003 FETCH SHALL assert mem_req=1 and mem_write=0, and hold until mem_ready=1. In the mem_ready cycle it SHALL assert ir_write=1 and pc_write=1 (pc_src=0, jump=0) and go to DECODE.
REQ-004 DECODE SHALL dispatch on opcode:
- 000000 -> R_EXEC
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDI_EXEC
- any other -> FETCH, with illegal=1 for exactly that cycle.
REQ-005 MEM_ADDR SHALL drive alu_src=1 and alu_op=00. It SHALL go to MEM_READ if the DECODE-latched opcode was 100011, else to MEM_WRITE.
REQ-006 The opcode SHALL be latched internally in DECODE, so later states are immune to opcode changes.
REQ-007 MEM_READ SHALL assert mem_req=1 and mem_write=0, and hold until mem_ready=1, then go to MEM_WB.
REQ-008 MEM_WB SHALL assert reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-009 MEM_WRITE SHALL assert mem_req=1 and mem_write=1, and hold until mem_ready=1, then go to FETCH.
REQ-010 R_EXEC SHALL drive alu_src=0 and alu_op=10, then go to R_WB. R_WB SHALL assert reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-011 BRANCH SHALL drive alu_src=0, alu_op=01 and pc_src=1. It SHALL assert pc_write=zero (same-cycle, Mealy), then go to FETCH.
REQ-012 JUMP SHALL assert jump=1 and pc_write=1, then go to FETCH.
REQ-013 ADDI_EXEC SHALL drive alu_src=1 and alu_op=00, then go to ADDI_WB. ADDI_WB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-014 Any output not named for a state SHALL be 0 in that state, including mem_req, reg_write and pc_write.
REQ-015 Strobe outputs SHALL never be asserted in an undefined encoding (12-15). Any undefined encoding SHALL go to FETCH on the next edge.
REQ-016 retired SHALL increment by 1, modulo 2^16 (FFFF -> 0000), on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB. An illegal dispatch SHALL NOT increment it.
REQ-017 An instruction's cycle count SHALL be fixed as follows, with each wait state adding cycles while mem_ready=0:
- R-type: 4
- lw: 5
- sw: 4
- beq: 3
- j: 3
- addi: 4
REQ-018 A mem_ready pulse in a state without mem_req SHALL be ignored.

Reset
REQ-019 With reset=0 at a rising edge, the next state SHALL be FETCH, retired SHALL be 0 and the latched opcode SHALL be 000000. This SHALL apply from any state, including mid memory wait.
REQ-020 During reset, all outputs other than FETCH's mem_req=1 SHALL be 0, and illegal SHALL be 0.
REQ-021 Reset SHALL have priority over mem_ready and dispatch.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- lw (100011), mem_ready=1 every request -> state 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; retired=1.
- beq (000100), zero=1 then repeat with zero=0 -> pc_write=1 with pc_src=1 in state 8, then pc_write=0 in state 8; retired=2.
- FETCH with mem_ready=0 for 3 cycles -> state stays 0 with mem_req=1 for 4 cycles; ir_write=1 only in the final cycle.
- opcode 111111 in DECODE -> illegal pulses 1 cycle, next state 0, retired unchanged.
- reset=0 asserted in MEM_WRITE while waiting -> next state 0, mem_write=0, retired=0.
- retired preloaded via 65535 j instructions, then one more -> retired wraps to 0x0000.
